uart_word_handler: RTL and testbench
====================================

# uart_word_handler

Parametrised successor to the byte-level UART loopback handler. Sits between the `uart` core's FIFO ports (rx side: `rd`/`rd_empty`/`r_data`; tx side: `wr`/`wr_full`/`w_data`) and a word-wide host interface. It does three things:
- Assembles received bytes into `WORD_BYTES`-wide words.
- Serialises host words back to bytes.
- Optionally loops assembled words straight back to the transmitter, which is the old echo behaviour generalised to words.

## Interface
Parameters:
- `WORD_BYTES`, 4: bytes per word; legal range 1–8.
- `TIMEOUT_CYCLES`, 1000000: inter-byte idle limit before a partial word is discarded. Only used with `UART_WORD_TIMEOUT_EN`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: the single clock.
  - `reset` in 1: asynchronous, active-low.
- UART-core FIFO side:
  - `rx_empty` in 1: the uart rx FIFO is empty.
  - `rx_data` in 8: head of the rx FIFO.
  - `rx_rd` out 1: pop the rx FIFO.
  - `tx_full` in 1: the uart tx FIFO is full.
  - `tx_data` out 8: byte to write.
  - `tx_wr` out 1: push to the tx FIFO.
- Host side:
  - `loopback` in 1: 1 = echo assembled words, 0 = deliver them to the host.
  - `rx_word` out 8*WORD_BYTES: assembled word.
  - `rx_word_valid` out 1, `rx_word_ready` in 1: rx handshake.
  - `tx_word` in 8*WORD_BYTES: word to send.
  - `tx_word_valid` in 1, `tx_word_ready` out 1: tx handshake.
- Status:
  - `timeout_err` out 1: one-cycle pulse when a partial word is discarded.

## Operation
- **Byte order:** little-endian both directions. First byte received or sent is bits [7:0].
- **RX assembler FSM** (states R_COLLECT, R_HOLD):
  - R_COLLECT: `rx_rd = ~rx_empty` (combinational). On each clock edge where `rx_rd` = 1, `rx_data` is stored in byte lane `cnt` and `cnt` increments.
  - When the `WORD_BYTES`-th byte is captured, the FSM moves to R_HOLD and `cnt` returns to 0.
  - R_HOLD: `rx_rd` = 0.
    - `mode_q` = 0: `rx_word_valid` = 1. Leave for R_COLLECT on `rx_word_valid & rx_word_ready`.
    - `mode_q` = 1: `rx_word_valid` = 0. The word is handed to the serialiser when it is in T_IDLE, then the FSM returns to R_COLLECT.
- **TX serialiser FSM** (states T_IDLE, T_SEND):
  - T_IDLE: `tx_word_ready = ~mode_q`. On `tx_word_valid & tx_word_ready` (or a loopback hand-off), load the shift register, clear the byte counter and go to T_SEND.
  - T_SEND: `tx_data = shift[7:0]` and `tx_wr = ~tx_full`. Each write shifts right by 8 and increments the counter.
  - After the `WORD_BYTES`-th write the FSM returns to T_IDLE.
- **Mode register `mode_q`:**
  - Loads `loopback` only when the RX FSM is in R_COLLECT with `cnt` = 0 and the TX FSM is in T_IDLE.
  - Otherwise it holds, so a mode change never splits a word.
- **Width rules:**
  - Byte counters are `$clog2(WORD_BYTES+1)` bits.
  - The timeout counter is `$clog2(TIMEOUT_CYCLES)` bits and saturates.

## Timing
- **Reset values:**
  - `rx_rd` = 0, `rx_word` = 0, `rx_word_valid` = 0.
  - `tx_wr` = 0, `tx_data` = 0.
  - `timeout_err` = 0.
  - `mode_q` = 0, so `tx_word_ready` = 1.
  - FSMs in R_COLLECT and T_IDLE; all counters 0.
- **RX latency:** `rx_word_valid` rises in the cycle after the edge that captures the last byte.
- **RX throughput:** one byte per cycle.
- **RX hand-off:** after a host handshake, R_COLLECT resumes the next cycle.
- **TX latency:** the first `tx_wr` can occur in the cycle after acceptance.
- **TX throughput:** `WORD_BYTES` cycles minimum per word; each `tx_full` cycle adds one stall cycle.
- **Stall rules:**
  - `rx_word` and `rx_word_valid` stay stable while `rx_word_ready` = 0.
  - `tx_data` stays stable while `tx_full` = 1.
- **Loopback:** while the serialiser is busy, R_HOLD waits and the rx FIFO back-pressures naturally.
- **Reset mid-word:** any partial rx word or in-flight tx word is dropped immediately; nothing is flushed.

## Configuration
- Macro: `UART_WORD_TIMEOUT_EN`.
- **Defined:**
  - The timeout counter clears on every rx pop and counts only while 0 < `cnt` < `WORD_BYTES` in R_COLLECT.
  - On reaching `TIMEOUT_CYCLES`-1 the counter sets `cnt` = 0, discards the partial word and pulses `timeout_err` for one cycle.
  - A byte popped in that same cycle wins: it is captured and the counter clears.
- **Undefined:** there is no counter, a partial word waits indefinitely, and `timeout_err` is tied to 0.

## Structure
- Package `uart_word_pkg` holds:
  - `BYTE_W` = 8.
  - Enums `rx_state_t` {R_COLLECT, R_HOLD} and `tx_state_t` {T_IDLE, T_SEND}.
- Sub-module `uart_word_serializer` holds the TX FSM, shift register and counter.
- The top level holds the RX assembler, `mode_q`, the loopback mux and the timeout.

## Test plan
- **Assemble:** `WORD_BYTES` = 4, `loopback` = 0, rx FIFO presents 0x11, 0x22, 0x33, 0x44 back-to-back → `rx_word` = 0x44332211 with `rx_word_valid` 1 cycle after the 4th pop; `rx_rd` stays 0 until the handshake.
- **Serialise:** `tx_word` = 0xA1B2C3D4 accepted, `tx_full` high for 2 cycles mid-word → `tx_wr` bytes D4, C3, B2, A1 in order; `tx_data` is stable during the stall; `tx_word_ready` returns 1 after the 4th write.
- **Loopback echo:** `loopback` = 1, rx bytes 0x01..0x08 → tx emits 01..08; `rx_word_valid` never asserts; `tx_word_ready` = 0.
- **Mode change mid-word:** `loopback` toggles after 2 of 4 bytes → the current word follows the old mode and the next word follows the new mode.
- **Timeout** (`UART_WORD_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16): 2 bytes then idle → `timeout_err` pulses once, 15 cycles after the 2nd pop; the next 4 bytes form a clean word.
- **Async reset:** `reset` = 0 during T_SEND byte 2 → `tx_wr` = 0 immediately; after release the outputs hold their reset values and `tx_word_ready` = 1.

Source files
------------

// File: rtl/uart_word_pkg.sv
// Shared types and constants for the UART word handler.
package uart_word_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic {R_COLLECT, R_HOLD} rx_state_t;
  typedef enum logic {T_IDLE, T_SEND} tx_state_t;

  // Width of a counter that must hold 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/uart_word_handler_if.sv
// Bundle of uart-core FIFO signals, host word handshakes and status.
// slave = the word handler, master = whatever drives it.
interface uart_word_handler_if
  import uart_word_pkg::*;
#(
  parameter int WORD_BYTES = 4
);
  logic                         rx_empty;
  logic [BYTE_W-1:0]            rx_data;
  logic                         rx_rd;
  logic                         tx_full;
  logic [BYTE_W-1:0]            tx_data;
  logic                         tx_wr;
  logic                         loopback;
  logic [BYTE_W*WORD_BYTES-1:0] rx_word;
  logic                         rx_word_valid;
  logic                         rx_word_ready;
  logic [BYTE_W*WORD_BYTES-1:0] tx_word;
  logic                         tx_word_valid;
  logic                         tx_word_ready;
  logic                         timeout_err;

  modport slave (
    input  rx_empty, rx_data, tx_full, loopback, rx_word_ready, tx_word, tx_word_valid,
    output rx_rd, tx_data, tx_wr, rx_word, rx_word_valid, tx_word_ready, timeout_err
  );

  modport master (
    output rx_empty, rx_data, tx_full, loopback, rx_word_ready, tx_word, tx_word_valid,
    input  rx_rd, tx_data, tx_wr, rx_word, rx_word_valid, tx_word_ready, timeout_err
  );
endinterface

// File: rtl/uart_word_serializer.sv
// Word-to-byte serialiser: loads a word, emits it LSB byte first into the
// uart tx FIFO, stalling on tx_full.
module uart_word_serializer
  import uart_word_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [BYTE_W*WORD_BYTES-1:0] load_word,
  input  logic                         tx_full,
  output logic                         tx_wr,
  output logic [BYTE_W-1:0]            tx_data,
  output logic                         idle
);
  localparam int CW = cnt_w(WORD_BYTES);

  tx_state_t                    st;
  logic [BYTE_W*WORD_BYTES-1:0] shift;
  logic [CW-1:0]                bcnt;

  assign idle    = (st == T_IDLE);
  assign tx_wr   = (st == T_SEND) & ~tx_full;
  assign tx_data = shift[BYTE_W-1:0];

  // TX FSM: load on accept, shift one byte out per non-full cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st    <= T_IDLE;
      shift <= '0;
      bcnt  <= '0;
    end else begin
      case (st)
        T_IDLE: if (load) begin
          shift <= load_word;
          bcnt  <= '0;
          st    <= T_SEND;
        end
        T_SEND: if (!tx_full) begin
          shift <= shift >> BYTE_W;
          if (bcnt == CW'(WORD_BYTES - 1)) begin
            bcnt <= '0;
            st   <= T_IDLE;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: st <= T_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_word_handler.sv
// UART word handler: assembles rx bytes into little-endian words, serialises
// host words to bytes, and optionally echoes assembled words (loopback).
// Optional feature macro: UART_WORD_TIMEOUT_EN (inter-byte timeout that
// discards a partial rx word and pulses timeout_err).
module uart_word_handler
  import uart_word_pkg::*;
#(
  parameter int WORD_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic                clk,
  input logic                reset,
  uart_word_handler_if.slave bus
);
  localparam int CW = cnt_w(WORD_BYTES);
  localparam int W  = BYTE_W * WORD_BYTES;

  rx_state_t     rx_st;
  logic [CW-1:0] cnt;
  logic [W-1:0]  word_q;
  logic          mode_q;
  logic          rx_pop, last_byte, lb_go, ser_idle, ser_load, tmo_hit;

  assign rx_pop            = (rx_st == R_COLLECT) & ~bus.rx_empty;
  assign bus.rx_rd         = rx_pop;
  assign last_byte         = (cnt == CW'(WORD_BYTES - 1));
  // Loopback hand-off: held word goes to the serialiser once it is idle.
  assign lb_go             = (rx_st == R_HOLD) & mode_q & ser_idle;
  assign bus.rx_word_valid = (rx_st == R_HOLD) & ~mode_q;
  assign bus.rx_word       = word_q;
  assign bus.tx_word_ready = ser_idle & ~mode_q;
  assign ser_load          = lb_go | (bus.tx_word_valid & bus.tx_word_ready);

  // RX assembler: capture one byte per pop into lane cnt, hold until consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_st  <= R_COLLECT;
      cnt    <= '0;
      word_q <= '0;
    end else begin
      case (rx_st)
        R_COLLECT: begin
          if (rx_pop) begin
            word_q[cnt*BYTE_W +: BYTE_W] <= bus.rx_data;
            if (last_byte) begin
              cnt   <= '0;
              rx_st <= R_HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (tmo_hit) begin
            cnt <= '0;
          end
        end
        R_HOLD: if ((~mode_q & bus.rx_word_ready) | lb_go) rx_st <= R_COLLECT;
        default: rx_st <= R_COLLECT;
      endcase
    end
  end

  // Mode only changes between words so no word is ever split across modes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mode_q <= 1'b0;
    else if (rx_st == R_COLLECT && cnt == '0 && ser_idle)
      mode_q <= bus.loopback;
  end

`ifdef UART_WORD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tmo_cnt;
  logic          tmo_run, terr_q;

  // Only a partial word ages; a pop in the same cycle always wins.
  assign tmo_run = (rx_st == R_COLLECT) && (cnt != '0) && !rx_pop;
  assign tmo_hit = tmo_run && (tmo_cnt == TW'(TIMEOUT_CYCLES - 2));
  assign bus.timeout_err = terr_q;

  // Saturating idle counter, cleared by every rx pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
      terr_q  <= 1'b0;
    end else begin
      terr_q <= tmo_hit;
      if (rx_pop)
        tmo_cnt <= '0;
      else if (tmo_run && tmo_cnt != '1)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  uart_word_serializer #(.WORD_BYTES(WORD_BYTES)) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .load_word (mode_q ? word_q : bus.tx_word),
    .tx_full   (bus.tx_full),
    .tx_wr     (bus.tx_wr),
    .tx_data   (bus.tx_data),
    .idle      (ser_idle)
  );
endmodule

// File: tb/tb_uart_word_handler.sv
// Directed bench for uart_word_handler (WORD_BYTES=4, TIMEOUT_CYCLES=16).
module tb_uart_word_handler;
  logic clk, reset;
  uart_word_handler_if #(.WORD_BYTES(4)) bus();

  uart_word_handler #(.WORD_BYTES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0, pass_cnt = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  int valid_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // rx FIFO model: pops when the DUT read at the edge, presents head shortly after.
  task automatic present();
    bus.rx_empty = (rxq.size() == 0);
    bus.rx_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
  endtask

  initial forever begin
    logic rd_s;
    @(posedge clk);
    rd_s = bus.rx_rd;
    #1;
    if (rd_s && rxq.size() > 0) void'(rxq.pop_front());
    present();
    @(negedge clk);
    #1 present();
  end

  // tx FIFO and rx_word_valid monitors.
  always @(posedge clk) if (bus.tx_wr) txq.push_back(bus.tx_data);
  always @(posedge clk) if (bus.rx_word_valid) valid_cnt++;

  task automatic tick(); @(negedge clk); endtask

  task automatic push_seq(input logic [31:0] seq, input int n);
    for (int i = 0; i < n; i++) rxq.push_back(seq[31-8*i -: 8]);
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!bus.rx_word_valid && n < 50) begin tick(); n++; end
    chk(nm, bus.rx_word_valid, 1);
  endtask

  task automatic rx_take();
    bus.rx_word_ready = 1'b1;
    tick();
    bus.rx_word_ready = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    while (!bus.tx_word_ready && n < 50) begin tick(); n++; end
    chk("tx_ready_wait", bus.tx_word_ready, 1);
    bus.tx_word = w;
    bus.tx_word_valid = 1'b1;
    tick();
    bus.tx_word_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n_total, input string nm);
    int n = 0;
    while (txq.size() < n_total && n < 100) begin tick(); n++; end
    chk(nm, txq.size(), n_total);
  endtask

  typedef struct { logic [31:0] seq; logic [31:0] exp; } vec_t;
  vec_t rx_tab[4];
  vec_t tx_tab[4];

  initial begin
    int base, v0, hits, hit_i;

    rx_tab[0] = '{32'h11223344, 32'h44332211};
    rx_tab[1] = '{32'hDEADBEEF, 32'hEFBEADDE};
    rx_tab[2] = '{32'h00FF00FF, 32'hFF00FF00};
    rx_tab[3] = '{32'h80000001, 32'h01000080};
    // tx: seq = word, exp = bytes in wire order (first byte in [31:24]).
    tx_tab[0] = '{32'hA1B2C3D4, 32'hD4C3B2A1};
    tx_tab[1] = '{32'h01234567, 32'h67452301};
    tx_tab[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    tx_tab[3] = '{32'h00000080, 32'h80000000};

    reset = 1'b1;
    bus.rx_empty = 1'b1; bus.rx_data = '0; bus.tx_full = 1'b0; bus.loopback = 1'b0;
    bus.rx_word_ready = 1'b0; bus.tx_word = '0; bus.tx_word_valid = 1'b0;
    #1 reset = 1'b0;
    tick(); tick();
    chk("rst_rx_rd", bus.rx_rd, 0);
    chk("rst_rx_word", bus.rx_word, 0);
    chk("rst_rx_valid", bus.rx_word_valid, 0);
    chk("rst_tx_wr", bus.tx_wr, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_timeout", bus.timeout_err, 0);
    chk("rst_tx_ready", bus.tx_word_ready, 1);
    reset = 1'b1;
    tick();

    // Assemble, cycle by cycle.
    push_seq(32'h11223344, 4);
    tick(); chk("asm_rd1", bus.rx_rd, 1);
    tick(); tick(); chk("asm_valid_early", bus.rx_word_valid, 0);
    tick(); chk("asm_valid", bus.rx_word_valid, 1);
    chk("asm_word", bus.rx_word, 32'h44332211);
    chk("asm_rd_hold", bus.rx_rd, 0);
    push_seq(32'h55667788, 4);
    tick();
    chk("asm_rd_blocked", bus.rx_rd, 0);
    chk("asm_stable", bus.rx_word, 32'h44332211);
    chk("asm_valid_stable", bus.rx_word_valid, 1);
    rx_take();
    chk("asm_release", bus.rx_word_valid, 0);
    chk("asm_resume", bus.rx_rd, 1);
    wait_valid("asm2_valid");
    chk("asm2_word", bus.rx_word, 32'h88776655);
    rx_take();

    for (int i = 0; i < 4; i++) begin
      push_seq(rx_tab[i].seq, 4);
      wait_valid("rxtab_valid");
      chk("rxtab_word", bus.rx_word, rx_tab[i].exp);
      rx_take();
    end

    // Serialise with a two-cycle tx_full stall.
    base = txq.size();
    chk("ser_ready", bus.tx_word_ready, 1);
    send_word(32'hA1B2C3D4);
    chk("ser_wr0", bus.tx_wr, 1);
    chk("ser_d0", bus.tx_data, 8'hD4);
    chk("ser_busy", bus.tx_word_ready, 0);
    tick();
    chk("ser_d1", bus.tx_data, 8'hC3);
    bus.tx_full = 1'b1;
    tick(); chk("ser_stall_wr", bus.tx_wr, 0); chk("ser_stall_d", bus.tx_data, 8'hC3);
    tick(); chk("ser_stall_d2", bus.tx_data, 8'hC3);
    bus.tx_full = 1'b0;
    tick(); tick(); tick();
    chk("ser_ready_back", bus.tx_word_ready, 1);
    chk("ser_wr_done", bus.tx_wr, 0);
    chk("ser_count", txq.size(), base + 4);
    chk("ser_bytes", {txq[base], txq[base+1], txq[base+2], txq[base+3]}, 32'hD4C3B2A1);

    for (int i = 0; i < 4; i++) begin
      base = txq.size();
      send_word(tx_tab[i].seq);
      wait_tx(base + 4, "txtab_count");
      if (txq.size() >= base + 4)
        chk("txtab_bytes", {txq[base], txq[base+1], txq[base+2], txq[base+3]}, tx_tab[i].exp);
    end

    // Loopback echo of two words.
    bus.loopback = 1'b1;
    tick(); tick();
    chk("lb_tx_ready", bus.tx_word_ready, 0);
    base = txq.size(); v0 = valid_cnt;
    push_seq(32'h01020304, 4);
    push_seq(32'h05060708, 4);
    tick(); tick(); tick();
    chk("lb_tx_ready_mid", bus.tx_word_ready, 0);
    wait_tx(base + 8, "lb_count");
    if (txq.size() >= base + 8) begin
      chk("lb_bytes_lo", {txq[base], txq[base+1], txq[base+2], txq[base+3]}, 32'h01020304);
      chk("lb_bytes_hi", {txq[base+4], txq[base+5], txq[base+6], txq[base+7]}, 32'h05060708);
    end
    chk("lb_no_valid", valid_cnt, v0);
    bus.loopback = 1'b0;
    tick(); tick(); tick();
    chk("lb_exit_ready", bus.tx_word_ready, 1);

    // Mode change after 2 of 4 bytes: word stays on host, next word echoes.
    base = txq.size();
    push_seq(32'hAABB0000, 2);
    tick(); tick(); tick();
    bus.loopback = 1'b1;
    push_seq(32'hCCDD0000, 2);
    wait_valid("mc_valid");
    chk("mc_word", bus.rx_word, 32'hDDCCBBAA);
    chk("mc_no_tx", txq.size(), base);
    rx_take();
    v0 = valid_cnt;
    push_seq(32'h31323334, 4);
    wait_tx(base + 4, "mc_echo_count");
    if (txq.size() >= base + 4)
      chk("mc_echo", {txq[base], txq[base+1], txq[base+2], txq[base+3]}, 32'h31323334);
    chk("mc_echo_no_valid", valid_cnt, v0);
    bus.loopback = 1'b0;
    tick(); tick(); tick();

    // Partial word followed by a long idle gap.
    hits = 0; hit_i = -1;
    push_seq(32'h5A6B0000, 2);
    tick(); tick();
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.timeout_err) begin hits++; hit_i = i; end
    end
`ifdef UART_WORD_TIMEOUT_EN
    chk("tmo_pulses", hits, 1);
    chk("tmo_when", hit_i, 15);
    push_seq(32'h7C8D9EAF, 4);
    wait_valid("tmo_clean_valid");
    chk("tmo_clean_word", bus.rx_word, 32'hAF9E8D7C);
`else
    chk("notmo_pulses", hits, 0);
    push_seq(32'h7C8D0000, 2);
    wait_valid("notmo_valid");
    chk("notmo_word", bus.rx_word, 32'h8D7C6B5A);
`endif
    rx_take();

    // Async reset while the second byte of a word is pending.
    base = txq.size();
    send_word(32'h0F0E0D0C);
    tick();
    chk("arst_pre_wr", bus.tx_wr, 1);
    chk("arst_pre_d", bus.tx_data, 8'h0D);
    #2 reset = 1'b0;
    #1;
    chk("arst_wr", bus.tx_wr, 0);
    chk("arst_d", bus.tx_data, 0);
    chk("arst_ready", bus.tx_word_ready, 1);
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    chk("arst_post_wr", bus.tx_wr, 0);
    chk("arst_post_ready", bus.tx_word_ready, 1);
    chk("arst_post_word", bus.rx_word, 0);
    chk("arst_post_valid", bus.rx_word_valid, 0);
    chk("arst_one_byte", txq.size(), base + 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
